// File: rtl/cpu_types_pkg.sv
// Basic CPU-wide data types.
package cpu_types_pkg;

    localparam int unsigned WordWidth = 32;

    typedef logic [WordWidth-1:0] word_t;

endpackage

// File: rtl/data_path_muxs_pkg.sv
// Select encodings for datapath muxes and the fetch sequencer state type.
package data_path_muxs_pkg;

    typedef enum logic [1:0] {
        SEL_NPC,
        SEL_BRANCH,
        SEL_JUMP,
        SEL_JR
    } pc_mux_input_selection;

    typedef enum logic [1:0] {
        StRun,
        StPend,
        StHalted
    } fetch_state_t;

endpackage

// File: rtl/redirect_buf.sv
// Single-entry holding register for a redirect that arrived while the PC was stalled.
module redirect_buf
    import cpu_types_pkg::*;
    import data_path_muxs_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  capture_i,
    input  logic                  clear_i,
    input  pc_mux_input_selection sel_i,
    input  word_t                 jr_addr_i,
    input  logic [25:0]           load_addr_i,
    input  logic [15:0]           load_imm_i,
    output logic                  valid_o,
    output pc_mux_input_selection sel_o,
    output word_t                 jr_addr_o,
    output logic [25:0]           load_addr_o,
    output logic [15:0]           load_imm_o
);

    logic                  valid_q, valid_d;
    pc_mux_input_selection sel_q, sel_d;
    word_t                 jr_addr_q, jr_addr_d;
    logic [25:0]           load_addr_q, load_addr_d;
    logic [15:0]           load_imm_q, load_imm_d;

    // Clear wins over capture so a halt always leaves the buffer empty.
    always_comb begin
        valid_d     = valid_q;
        sel_d       = sel_q;
        jr_addr_d   = jr_addr_q;
        load_addr_d = load_addr_q;
        load_imm_d  = load_imm_q;
        if (clear_i) begin
            valid_d     = 1'b0;
            sel_d       = SEL_NPC;
            jr_addr_d   = '0;
            load_addr_d = '0;
            load_imm_d  = '0;
        end else if (capture_i) begin
            valid_d     = 1'b1;
            sel_d       = sel_i;
            jr_addr_d   = jr_addr_i;
            load_addr_d = load_addr_i;
            load_imm_d  = load_imm_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q     <= 1'b0;
            sel_q       <= SEL_NPC;
            jr_addr_q   <= '0;
            load_addr_q <= '0;
            load_imm_q  <= '0;
        end else begin
            valid_q     <= valid_d;
            sel_q       <= sel_d;
            jr_addr_q   <= jr_addr_d;
            load_addr_q <= load_addr_d;
            load_imm_q  <= load_imm_d;
        end
    end

    assign valid_o     = valid_q;
    assign sel_o       = sel_q;
    assign jr_addr_o   = jr_addr_q;
    assign load_addr_o = load_addr_q;
    assign load_imm_o  = load_imm_q;

endmodule

// File: rtl/fetch_ctrl.sv
// PC sequencer: advance/hold decision, PC mux select, redirect buffering,
// sticky halt and a fetch watchdog.
module fetch_ctrl
    import cpu_types_pkg::*;
    import data_path_muxs_pkg::*;
#(
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  ihit,
    input  logic                  stall_req,
    input  logic                  halt_req,
    input  logic                  redirect_valid,
    input  pc_mux_input_selection redirect_sel,
    input  word_t                 redirect_jr_addr,
    input  logic [25:0]           redirect_load_addr,
    input  logic [15:0]           redirect_load_imm,
    output pc_mux_input_selection PCSrc,
    output logic                  pc_wait,
    output logic                  halt,
    output word_t                 jr_addr,
    output logic [25:0]           load_addr,
    output logic [15:0]           load_imm,
    output logic                  iREN,
    output logic                  flush_fetch,
    output logic                  fetch_timeout
);

    localparam int unsigned CntW = $clog2(WDOG_CYCLES) + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(WDOG_CYCLES);

    fetch_state_t state_q, state_d;
    logic         halted, adv;

    logic                  buf_capture, buf_clear, buf_valid;
    pc_mux_input_selection buf_sel;
    word_t                 buf_jr_addr;
    logic [25:0]           buf_load_addr;
    logic [15:0]           buf_load_imm;

    pc_mux_input_selection eff_sel;
    word_t                 eff_jr_addr;
    logic [25:0]           eff_load_addr;
    logic [15:0]           eff_load_imm;

    logic [CntW-1:0] wdog_q, wdog_d;
    logic            timeout_q, timeout_d;

    assign halted = (state_q == StHalted);
    assign adv    = ihit & ~stall_req & ~halted;

    always_comb begin
        state_d       = state_q;
        buf_capture   = 1'b0;
        buf_clear     = 1'b0;
        flush_fetch   = 1'b0;
        eff_sel       = SEL_NPC;
        eff_jr_addr   = '0;
        eff_load_addr = '0;
        eff_load_imm  = '0;
        unique case (state_q)
            StRun: begin
                if (halt_req) begin
                    state_d   = StHalted;
                    buf_clear = 1'b1;
                end else if (redirect_valid) begin
                    flush_fetch = 1'b1;
                    if (adv) begin
                        eff_sel       = redirect_sel;
                        eff_jr_addr   = redirect_jr_addr;
                        eff_load_addr = redirect_load_addr;
                        eff_load_imm  = redirect_load_imm;
                    end else begin
                        buf_capture = 1'b1;
                        state_d     = StPend;
                    end
                end
            end
            StPend: begin
                // First redirect wins; later ones in this state are dropped.
                if (buf_valid) begin
                    eff_sel       = buf_sel;
                    eff_jr_addr   = buf_jr_addr;
                    eff_load_addr = buf_load_addr;
                    eff_load_imm  = buf_load_imm;
                end
                if (halt_req) begin
                    state_d   = StHalted;
                    buf_clear = 1'b1;
                end else if (adv) begin
                    state_d   = StRun;
                    buf_clear = 1'b1;
                end
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d   = StRun;
                buf_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    redirect_buf u_redirect_buf (
        .clk_i       (CLK),
        .rst_ni      (nRST),
        .capture_i   (buf_capture),
        .clear_i     (buf_clear),
        .sel_i       (redirect_sel),
        .jr_addr_i   (redirect_jr_addr),
        .load_addr_i (redirect_load_addr),
        .load_imm_i  (redirect_load_imm),
        .valid_o     (buf_valid),
        .sel_o       (buf_sel),
        .jr_addr_o   (buf_jr_addr),
        .load_addr_o (buf_load_addr),
        .load_imm_o  (buf_load_imm)
    );

    // Targets not used by the effective select are driven to zero.
    assign PCSrc     = eff_sel;
    assign jr_addr   = (eff_sel == SEL_JR)     ? eff_jr_addr   : '0;
    assign load_addr = (eff_sel == SEL_JUMP)   ? eff_load_addr : '0;
    assign load_imm  = (eff_sel == SEL_BRANCH) ? eff_load_imm  : '0;

    assign pc_wait = ~adv | halt_req;
    assign iREN    = ~halted;
    assign halt    = halted;

    always_comb begin
        wdog_d = wdog_q;
        if (ihit) begin
            wdog_d = '0;
        end else if (iREN && (wdog_q != CntMax)) begin
            wdog_d = wdog_q + CntW'(1);
        end
        timeout_d = timeout_q | (wdog_d == CntMax);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign fetch_timeout = timeout_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a small reference PC driven by the DUT's PC controls.
module tb_fetch_ctrl;
    import cpu_types_pkg::*;
    import data_path_muxs_pkg::*;

    logic                  CLK;
    logic                  nRST;
    logic                  ihit, stall_req, halt_req, redirect_valid;
    pc_mux_input_selection redirect_sel;
    word_t                 redirect_jr_addr;
    logic [25:0]           redirect_load_addr;
    logic [15:0]           redirect_load_imm;
    pc_mux_input_selection PCSrc;
    logic                  pc_wait, halt, iREN, flush_fetch, fetch_timeout;
    word_t                 jr_addr;
    logic [25:0]           load_addr;
    logic [15:0]           load_imm;

    int    checks = 0;
    int    errors = 0;
    word_t pc_m;
    word_t pc_nx;

    fetch_ctrl #(.WDOG_CYCLES(8)) dut (
        .CLK                (CLK),
        .nRST               (nRST),
        .ihit               (ihit),
        .stall_req          (stall_req),
        .halt_req           (halt_req),
        .redirect_valid     (redirect_valid),
        .redirect_sel       (redirect_sel),
        .redirect_jr_addr   (redirect_jr_addr),
        .redirect_load_addr (redirect_load_addr),
        .redirect_load_imm  (redirect_load_imm),
        .PCSrc              (PCSrc),
        .pc_wait            (pc_wait),
        .halt               (halt),
        .jr_addr            (jr_addr),
        .load_addr          (load_addr),
        .load_imm           (load_imm),
        .iREN               (iREN),
        .flush_fetch        (flush_fetch),
        .fetch_timeout      (fetch_timeout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

    // Inputs change at posedge+1; outputs are read at the following negedge.
    task automatic settle();
        @(negedge CLK);
    endtask

    // Reference PC: update from the DUT's controls as the PC register would.
    task automatic advance();
        pc_nx = pc_m;
        if (!pc_wait) begin
            case (PCSrc)
                SEL_NPC:    pc_nx = pc_m + 32'd4;
                SEL_BRANCH: pc_nx = pc_m + 32'd4 + {{14{load_imm[15]}}, load_imm, 2'b00};
                SEL_JUMP:   pc_nx = {pc_m[31:28], load_addr, 2'b00};
                SEL_JR:     pc_nx = jr_addr;
                default:    pc_nx = pc_m;
            endcase
        end
        @(posedge CLK);
        #1;
        pc_m = pc_nx;
    endtask

    task automatic clear_inputs();
        ihit               = 1'b0;
        stall_req          = 1'b0;
        halt_req           = 1'b0;
        redirect_valid     = 1'b0;
        redirect_sel       = SEL_NPC;
        redirect_jr_addr   = '0;
        redirect_load_addr = '0;
        redirect_load_imm  = '0;
    endtask

    task automatic pulse_reset();
        clear_inputs();
        nRST = 1'b0;
        #2;
        nRST = 1'b1;
        pc_m = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        ihit = 1'b1;
        nRST = 1'b0;
        pc_m = '0;
        settle();
        checks++;
        if (PCSrc !== SEL_NPC) begin
            errors++; $display("FAIL reset_pcsrc: got %0d expected %0d", PCSrc, SEL_NPC);
        end
        checks++;
        if ({halt, iREN, flush_fetch, fetch_timeout} !== 4'b0100) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0100",
                     {halt, iREN, flush_fetch, fetch_timeout});
        end
        checks++;
        if (pc_wait !== 1'b0) begin
            errors++; $display("FAIL reset_pcwait_ihit1: got %b expected 0", pc_wait);
        end
        ihit = 1'b0;
        #1;
        checks++;
        if (pc_wait !== 1'b1) begin
            errors++; $display("FAIL reset_pcwait_ihit0: got %b expected 1", pc_wait);
        end
        #1;
        nRST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_sequential();
        ihit = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++;
            if (PCSrc !== SEL_NPC || pc_wait !== 1'b0) begin
                errors++;
                $display("FAIL seq_cycle%0d: got PCSrc %0d pc_wait %b expected 0 0",
                         i, PCSrc, pc_wait);
            end
            advance();
        end
        checks++;
        if (pc_m !== 32'h10) begin
            errors++; $display("FAIL seq_pc: got %h expected 00000010", pc_m);
        end
    endtask

    task automatic test_jr();
        ihit             = 1'b1;
        redirect_valid   = 1'b1;
        redirect_sel     = SEL_JR;
        redirect_jr_addr = 32'h40;
        redirect_load_imm = 16'h1234;
        settle();
        checks++;
        if (PCSrc !== SEL_JR || jr_addr !== 32'h40 || flush_fetch !== 1'b1) begin
            errors++;
            $display("FAIL jr_same_cycle: got sel %0d jr %h flush %b expected 3 00000040 1",
                     PCSrc, jr_addr, flush_fetch);
        end
        checks++;
        if (load_imm !== 16'h0 || load_addr !== 26'h0) begin
            errors++;
            $display("FAIL jr_unused_zero: got imm %h addr %h expected 0 0", load_imm, load_addr);
        end
        advance();
        clear_inputs();
        ihit = 1'b1;
        checks++;
        if (pc_m !== 32'h40) begin
            errors++; $display("FAIL jr_pc: got %h expected 00000040", pc_m);
        end
        settle();
        checks++;
        if (PCSrc !== SEL_NPC || flush_fetch !== 1'b0) begin
            errors++;
            $display("FAIL jr_after: got sel %0d flush %b expected 0 0", PCSrc, flush_fetch);
        end
        advance();
    endtask

    task automatic test_pending();
        // pc_m is 0x44 here
        clear_inputs();
        redirect_valid     = 1'b1;
        redirect_sel       = SEL_BRANCH;
        redirect_load_imm  = 16'h0003;
        redirect_load_addr = 26'h123;
        settle();
        checks++;
        if (flush_fetch !== 1'b1 || pc_wait !== 1'b1) begin
            errors++;
            $display("FAIL pend_capture: got flush %b wait %b expected 1 1", flush_fetch, pc_wait);
        end
        advance();
        redirect_sel       = SEL_JUMP;
        redirect_load_addr = 26'h155;
        redirect_load_imm  = 16'h7777;
        settle();
        checks++;
        if (PCSrc !== SEL_BRANCH || load_imm !== 16'h3 || load_addr !== 26'h0
            || flush_fetch !== 1'b0) begin
            errors++;
            $display("FAIL pend_second_ignored: got sel %0d imm %h addr %h flush %b expected 1 3 0 0",
                     PCSrc, load_imm, load_addr, flush_fetch);
        end
        advance();
        clear_inputs();
        settle();
        checks++;
        if (PCSrc !== SEL_BRANCH || pc_wait !== 1'b1) begin
            errors++;
            $display("FAIL pend_hold: got sel %0d wait %b expected 1 1", PCSrc, pc_wait);
        end
        advance();
        ihit = 1'b1;
        settle();
        checks++;
        if (PCSrc !== SEL_BRANCH || load_imm !== 16'h3 || pc_wait !== 1'b0) begin
            errors++;
            $display("FAIL pend_apply: got sel %0d imm %h wait %b expected 1 3 0",
                     PCSrc, load_imm, pc_wait);
        end
        advance();
        checks++;
        if (pc_m !== 32'h54) begin
            errors++; $display("FAIL pend_pc: got %h expected 00000054", pc_m);
        end
        settle();
        checks++;
        if (PCSrc !== SEL_NPC || load_imm !== 16'h0 || fetch_timeout !== 1'b0) begin
            errors++;
            $display("FAIL pend_back_run: got sel %0d imm %h timeout %b expected 0 0 0",
                     PCSrc, load_imm, fetch_timeout);
        end
        advance();
    endtask

    task automatic test_stall_redirect();
        // ihit with stall: redirect buffered, applied on the very next advancing edge
        ihit             = 1'b1;
        stall_req        = 1'b1;
        redirect_valid   = 1'b1;
        redirect_sel     = SEL_JR;
        redirect_jr_addr = 32'h80;
        settle();
        checks++;
        if (pc_wait !== 1'b1 || flush_fetch !== 1'b1) begin
            errors++;
            $display("FAIL stall_capture: got wait %b flush %b expected 1 1", pc_wait, flush_fetch);
        end
        advance();
        clear_inputs();
        ihit = 1'b1;
        settle();
        checks++;
        if (PCSrc !== SEL_JR || jr_addr !== 32'h80 || pc_wait !== 1'b0) begin
            errors++;
            $display("FAIL stall_apply: got sel %0d jr %h wait %b expected 3 00000080 0",
                     PCSrc, jr_addr, pc_wait);
        end
        advance();
        checks++;
        if (pc_m !== 32'h80) begin
            errors++; $display("FAIL stall_pc: got %h expected 00000080", pc_m);
        end
    endtask

    task automatic test_halt();
        clear_inputs();
        ihit             = 1'b1;
        halt_req         = 1'b1;
        redirect_valid   = 1'b1;
        redirect_sel     = SEL_JR;
        redirect_jr_addr = 32'h99;
        settle();
        checks++;
        if (pc_wait !== 1'b1 || halt !== 1'b0) begin
            errors++;
            $display("FAIL halt_req_cycle: got wait %b halt %b expected 1 0", pc_wait, halt);
        end
        advance();
        clear_inputs();
        for (int i = 0; i < 20; i++) begin
            ihit           = i[0];
            redirect_valid = i[1];
            redirect_sel   = SEL_JUMP;
            redirect_load_addr = 26'h3ff;
            settle();
            checks++;
            if ({halt, iREN, pc_wait, flush_fetch} !== 4'b1010 || PCSrc !== SEL_NPC
                || load_addr !== 26'h0) begin
                errors++;
                $display("FAIL halted_cycle%0d: got hiwf %b sel %0d addr %h expected 1010 0 0",
                         i, {halt, iREN, pc_wait, flush_fetch}, PCSrc, load_addr);
            end
            advance();
        end
        checks++;
        if (pc_m !== 32'h80) begin
            errors++; $display("FAIL halt_pc_frozen: got %h expected 00000080", pc_m);
        end
    endtask

    task automatic test_reset_in_pend();
        pulse_reset();
        redirect_valid     = 1'b1;
        redirect_sel       = SEL_JUMP;
        redirect_load_addr = 26'h10;
        settle();
        checks++;
        if (halt !== 1'b0 || iREN !== 1'b1) begin
            errors++; $display("FAIL unhalt_by_reset: got halt %b iren %b expected 0 1", halt, iREN);
        end
        advance();
        clear_inputs();
        settle();
        checks++;
        if (PCSrc !== SEL_JUMP || load_addr !== 26'h10) begin
            errors++;
            $display("FAIL rst_pend_entered: got sel %0d addr %h expected 2 10", PCSrc, load_addr);
        end
        nRST = 1'b0;
        #1;
        checks++;
        if (PCSrc !== SEL_NPC || load_addr !== 26'h0 || iREN !== 1'b1 || flush_fetch !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: got sel %0d addr %h iren %b flush %b expected 0 0 1 0",
                     PCSrc, load_addr, iREN, flush_fetch);
        end
        #1;
        nRST = 1'b1;
        pc_m = '0;
        @(posedge CLK);
        #1;
        ihit = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++;
            if (PCSrc !== SEL_NPC || load_addr !== 26'h0) begin
                errors++;
                $display("FAIL rst_no_stale%0d: got sel %0d addr %h expected 0 0",
                         i, PCSrc, load_addr);
            end
            advance();
        end
        checks++;
        if (pc_m !== 32'h8) begin
            errors++; $display("FAIL rst_pc: got %h expected 00000008", pc_m);
        end
    endtask

    task automatic test_watchdog();
        pulse_reset();
        for (int i = 0; i < 7; i++) begin
            advance();
        end
        settle();
        checks++;
        if (fetch_timeout !== 1'b0) begin
            errors++; $display("FAIL wdog_early: got %b expected 0", fetch_timeout);
        end
        advance();
        settle();
        checks++;
        if (fetch_timeout !== 1'b1) begin
            errors++; $display("FAIL wdog_fire: got %b expected 1", fetch_timeout);
        end
        ihit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            advance();
        end
        settle();
        checks++;
        if (fetch_timeout !== 1'b1) begin
            errors++; $display("FAIL wdog_sticky: got %b expected 1", fetch_timeout);
        end
        nRST = 1'b0;
        #1;
        checks++;
        if (fetch_timeout !== 1'b0) begin
            errors++; $display("FAIL wdog_reset: got %b expected 0", fetch_timeout);
        end
        nRST = 1'b1;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jr();
        test_pending();
        test_stall_redirect();
        test_halt();
        test_reset_in_pend();
        test_watchdog();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
